// File: rtl/act_layer_sched.sv
// act_layer_sched: layer-level controller for the activation ping/pong mux.
//
// Accepts one layer command, emits the two mux config words (geometry, then total
// beat count), then issues row-sized 64-bit DMA read bursts. Bursts are throttled
// by a row credit (at most MAX_OUT_ROWS rows requested but not fully consumed).
// Consumed activations are tracked by watching act mux handshakes until the layer
// completes.
//
// Optional feature: define ACT_SCHED_PERF_EN to build the busy/starve performance
// counters; otherwise perf_busy/perf_starve are tied to zero.
//
// Ports:
//   clk, rst_n                   clock, synchronous active-low reset
//   cmd_valid/cmd_ready          layer command handshake
//   cmd_img_h/_w/_ch_grp/_base   layer geometry and activation base address
//   m_cfg_valid/ready/data       config words to the act mux
//   m_rd_valid/ready/addr/len    DMA read burst requests (len in 64-bit beats)
//   act_valid, act_ready         act mux output handshake (monitor only)
//   busy, done, err              status; done/err are single-cycle pulses
//   perf_busy, perf_starve       performance counters (zero unless enabled)
module act_layer_sched #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned MAX_OUT_ROWS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [11:0]       cmd_img_h,
    input  logic [11:0]       cmd_img_w,
    input  logic [6:0]        cmd_ch_grp,
    input  logic [ADDR_W-1:0] cmd_base,
    output logic              m_cfg_valid,
    input  logic              m_cfg_ready,
    output logic [31:0]       m_cfg_data,
    output logic              m_rd_valid,
    input  logic              m_rd_ready,
    output logic [ADDR_W-1:0] m_rd_addr,
    output logic [15:0]       m_rd_len,
    input  logic              act_valid,
    input  logic              act_ready,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       perf_busy,
    output logic [31:0]       perf_starve
);

    typedef enum logic [2:0] {
        StIdle,
        StCfg0,
        StCfg1,
        StRun,
        StDrain
    } state_e;

    localparam logic [18:0] MaxOut = 19'(MAX_OUT_ROWS);

    state_e            state_q, state_d;
    logic [11:0]       img_h_q, img_h_d;
    logic [11:0]       img_w_q, img_w_d;
    logic [6:0]        ch_grp_q, ch_grp_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [18:0]       rows_issued_q, rows_issued_d;
    logic [18:0]       rows_done_q, rows_done_d;
    logic [12:0]       beat_q, beat_d;
    logic [31:0]       fire_cnt_q, fire_cnt_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic [12:0]       row_beats;
    logic [18:0]       nrows;
    logic [31:0]       total;
    logic [ADDR_W-1:0] row_stride;
    logic [18:0]       outstanding;
    logic              fire;
    logic              counting;
    logic              last_fire;
    logic              rd_valid;
    logic              cmd_accept;
    logic              cmd_zero;

    assign row_beats   = {img_w_q, 1'b0};
    assign nrows       = 19'(img_h_q) * 19'(ch_grp_q);
    // Exact: 4095*4095*127*2 fits in 32 bits.
    assign total       = (32'(img_h_q) * 32'(img_w_q) * 32'(ch_grp_q)) << 1;
    assign row_stride  = ADDR_W'({img_w_q, 4'b0000});
    assign outstanding = rows_issued_q - rows_done_q;
    assign fire        = act_valid & act_ready;
    assign counting    = (state_q == StRun) || (state_q == StDrain);
    assign last_fire   = counting && fire && ((fire_cnt_q + 32'd1) == total);
    assign rd_valid    = (state_q == StRun) && (rows_issued_q < nrows) && (outstanding < MaxOut);
    assign cmd_accept  = (state_q == StIdle) && cmd_valid;
    assign cmd_zero    = (cmd_img_h == 12'd0) || (cmd_img_w == 12'd0) || (cmd_ch_grp == 7'd0);

    always_comb begin
        state_d       = state_q;
        img_h_d       = img_h_q;
        img_w_d       = img_w_q;
        ch_grp_d      = ch_grp_q;
        addr_d        = addr_q;
        rows_issued_d = rows_issued_q;
        rows_done_d   = rows_done_q;
        beat_d        = beat_q;
        fire_cnt_d    = fire_cnt_q;
        done_d        = 1'b0;
        err_d         = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cmd_accept) begin
                    img_h_d       = cmd_img_h;
                    img_w_d       = cmd_img_w;
                    ch_grp_d      = cmd_ch_grp;
                    addr_d        = cmd_base;
                    rows_issued_d = '0;
                    rows_done_d   = '0;
                    beat_d        = '0;
                    fire_cnt_d    = '0;
                    if (cmd_zero) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = StCfg0;
                    end
                end
            end
            StCfg0: begin
                if (m_cfg_ready) state_d = StCfg1;
            end
            StCfg1: begin
                if (m_cfg_ready) state_d = StRun;
            end
            StRun: begin
                // The address register only moves on a handshake, so addr/len
                // stay stable while a request is stalled.
                if (rd_valid && m_rd_ready) begin
                    rows_issued_d = rows_issued_q + 19'd1;
                    addr_d        = addr_q + row_stride;
                end
                if (rows_issued_q == nrows) state_d = StDrain;
            end
            StDrain: begin
            end
            default: state_d = StIdle;
        endcase

        if (counting && fire) begin
            fire_cnt_d = fire_cnt_q + 32'd1;
            if (beat_q == row_beats - 13'd1) begin
                beat_d      = '0;
                rows_done_d = rows_done_q + 19'd1;
            end else begin
                beat_d = beat_q + 13'd1;
            end
        end

        // Layer completion wins over any pending issue.
        if (last_fire) begin
            state_d = StIdle;
            done_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            img_h_q       <= '0;
            img_w_q       <= '0;
            ch_grp_q      <= '0;
            addr_q        <= '0;
            rows_issued_q <= '0;
            rows_done_q   <= '0;
            beat_q        <= '0;
            fire_cnt_q    <= '0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            img_h_q       <= img_h_d;
            img_w_q       <= img_w_d;
            ch_grp_q      <= ch_grp_d;
            addr_q        <= addr_d;
            rows_issued_q <= rows_issued_d;
            rows_done_q   <= rows_done_d;
            beat_q        <= beat_d;
            fire_cnt_q    <= fire_cnt_d;
            done_q        <= done_d;
            err_q         <= err_d;
        end
    end

    always_comb begin
        m_cfg_data = 32'd0;
        unique case (state_q)
            StCfg0:  m_cfg_data = {7'd0, 1'b0, img_h_q, img_w_q};
            StCfg1:  m_cfg_data = total;
            default: m_cfg_data = 32'd0;
        endcase
    end

    assign cmd_ready   = (state_q == StIdle);
    assign m_cfg_valid = (state_q == StCfg0) || (state_q == StCfg1);
    assign m_rd_valid  = rd_valid;
    assign m_rd_addr   = addr_q;
    assign m_rd_len    = {3'b000, row_beats};
    assign busy        = (state_q != StIdle);
    assign done        = done_q;
    assign err         = err_q;

`ifdef ACT_SCHED_PERF_EN
    logic [31:0] perf_busy_q, perf_busy_d;
    logic [31:0] perf_starve_q, perf_starve_d;

    always_comb begin
        perf_busy_d   = perf_busy_q;
        perf_starve_d = perf_starve_q;
        if (cmd_accept) begin
            perf_busy_d   = '0;
            perf_starve_d = '0;
        end else begin
            if (busy && (perf_busy_q != 32'hFFFF_FFFF)) begin
                perf_busy_d = perf_busy_q + 32'd1;
            end
            if (counting && act_ready && !act_valid && (perf_starve_q != 32'hFFFF_FFFF)) begin
                perf_starve_d = perf_starve_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_busy_q   <= '0;
            perf_starve_q <= '0;
        end else begin
            perf_busy_q   <= perf_busy_d;
            perf_starve_q <= perf_starve_d;
        end
    end

    assign perf_busy   = perf_busy_q;
    assign perf_starve = perf_starve_q;
`else
    assign perf_busy   = 32'd0;
    assign perf_starve = 32'd0;
`endif

endmodule

// File: tb/tb_act_layer_sched.sv
// Scoreboard bench for act_layer_sched: the model expands each accepted command into
// the expected config words and burst list; a negedge monitor compares every cycle.
module tb_act_layer_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [11:0] cmd_img_h;
    logic [11:0] cmd_img_w;
    logic [6:0]  cmd_ch_grp;
    logic [31:0] cmd_base;
    logic        m_cfg_valid;
    logic        m_cfg_ready;
    logic [31:0] m_cfg_data;
    logic        m_rd_valid;
    logic        m_rd_ready;
    logic [31:0] m_rd_addr;
    logic [15:0] m_rd_len;
    logic        act_valid;
    logic        act_ready;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] perf_busy;
    logic [31:0] perf_starve;

    always #5 clk = ~clk;

    act_layer_sched #(
        .ADDR_W      (32),
        .MAX_OUT_ROWS(4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_img_h  (cmd_img_h),
        .cmd_img_w  (cmd_img_w),
        .cmd_ch_grp (cmd_ch_grp),
        .cmd_base   (cmd_base),
        .m_cfg_valid(m_cfg_valid),
        .m_cfg_ready(m_cfg_ready),
        .m_cfg_data (m_cfg_data),
        .m_rd_valid (m_rd_valid),
        .m_rd_ready (m_rd_ready),
        .m_rd_addr  (m_rd_addr),
        .m_rd_len   (m_rd_len),
        .act_valid  (act_valid),
        .act_ready  (act_ready),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .perf_busy  (perf_busy),
        .perf_starve(perf_starve)
    );

    int checks = 0;
    int failures = 0;

    // Reference model state
    bit          mon_en = 1'b0;
    bit          active, run_m, done_pend, err_pend;
    logic [31:0] cfg_q[$];
    logic [47:0] req_q[$];
    int unsigned issued, nrows_m, fires, total_m, row_m, beats_avail;
    int unsigned perf_busy_m, perf_starve_m;
    int unsigned err_seen, done_seen;

    // Stimulus knobs (percent probability)
    int unsigned cfg_rdy_pct = 100, rd_rdy_pct = 100, act_v_pct = 100, act_r_pct = 100;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout required=completion t=%0t", name, $time);
    endtask

    task automatic model_reset();
        active = 0; run_m = 0; done_pend = 0; err_pend = 0;
        cfg_q.delete(); req_q.delete();
        issued = 0; nrows_m = 0; fires = 0; total_m = 0; row_m = 0; beats_avail = 0;
        perf_busy_m = 0; perf_starve_m = 0;
    endtask

    // Random ready/valid driver; act_valid only offered for beats actually requested.
    always @(posedge clk) begin
        #1;
        m_cfg_ready = ($urandom_range(99) < cfg_rdy_pct);
        m_rd_ready  = ($urandom_range(99) < rd_rdy_pct);
        act_ready   = ($urandom_range(99) < act_r_pct);
        act_valid   = (beats_avail > 0) && ($urandom_range(99) < act_v_pct);
    end

    // Monitor: compare current outputs against the model, then apply this cycle's handshakes.
    always @(negedge clk) begin
        if (mon_en) begin
            bit exp_rd;
            bit cur_active, cur_run;
            chk("cmd_ready", cmd_ready, !active);
            chk("busy", busy, active);
            chk("done", done, done_pend);
            chk("err", err, err_pend);
            chk("cfg_valid", m_cfg_valid, active && !run_m);
            if (m_cfg_valid && cfg_q.size() > 0) chk("cfg_data", m_cfg_data, cfg_q[0]);
            exp_rd = run_m && (issued < nrows_m) && ((issued - fires / row_m) < 4);
            chk("rd_valid", m_rd_valid, exp_rd);
            if (m_rd_valid && req_q.size() > 0) chk("rd_addr_len", {m_rd_addr, m_rd_len}, req_q[0]);
`ifdef ACT_SCHED_PERF_EN
            chk("perf_busy", perf_busy, perf_busy_m);
            chk("perf_starve", perf_starve, perf_starve_m);
`else
            chk("perf_busy_off", perf_busy, 0);
            chk("perf_starve_off", perf_starve, 0);
`endif
            if (err) err_seen++;
            if (done) done_seen++;
            cur_active = active;
            cur_run    = run_m;
            done_pend  = 0;
            err_pend   = 0;

            if (cmd_valid && cmd_ready) begin
                perf_busy_m   = 0;
                perf_starve_m = 0;
            end else begin
                if (cur_active) perf_busy_m++;
                if (cur_run && act_ready && !act_valid) perf_starve_m++;
            end

            if (cmd_valid && cmd_ready) begin
                if (cmd_img_h == 0 || cmd_img_w == 0 || cmd_ch_grp == 0) begin
                    err_pend = 1;
                end else begin
                    int unsigned h, w, g;
                    h = cmd_img_h; w = cmd_img_w; g = cmd_ch_grp;
                    active  = 1;
                    total_m = h * w * 2 * g;
                    nrows_m = h * g;
                    row_m   = 2 * w;
                    issued  = 0;
                    fires   = 0;
                    cfg_q.push_back({8'd0, cmd_img_h, cmd_img_w});
                    cfg_q.push_back(total_m);
                    for (int r = 0; r < int'(nrows_m); r++) begin
                        logic [31:0] a;
                        a = cmd_base + 32'(16 * w * r);
                        req_q.push_back({a, 16'(row_m)});
                    end
                end
            end
            if (m_cfg_valid && m_cfg_ready && cfg_q.size() > 0) begin
                void'(cfg_q.pop_front());
                if (cfg_q.size() == 0) run_m = 1;
            end
            if (m_rd_valid && m_rd_ready && req_q.size() > 0) begin
                void'(req_q.pop_front());
                issued++;
                beats_avail += row_m;
            end
            if (act_valid && act_ready && cur_run) begin
                fires++;
                if (beats_avail > 0) beats_avail--;
                if (fires == total_m) begin
                    done_pend = 1;
                    active    = 0;
                    run_m     = 0;
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, cmd_ready, 1);
        chk({tag, "_cfg_valid"}, m_cfg_valid, 0);
        chk({tag, "_rd_valid"}, m_rd_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_cfg_data"}, m_cfg_data, 0);
        chk({tag, "_addr_len"}, {m_rd_addr, m_rd_len}, 0);
    endtask

    task automatic do_reset();
        mon_en = 0;
        @(posedge clk);
        #1 rst_n = 0;
        cmd_valid = 0;
        @(posedge clk);
        #1 check_reset_outputs("reset");
        rst_n = 1;
        model_reset();
        mon_en = 1;
    endtask

    task automatic send_cmd(input int h, input int w, input int g, input logic [31:0] base);
        int n;
        @(posedge clk);
        #1;
        cmd_valid  = 1;
        cmd_img_h  = 12'(h);
        cmd_img_w  = 12'(w);
        cmd_ch_grp = 7'(g);
        cmd_base   = base;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cmd_ready && n < 200);
        if (!cmd_ready) fail_now("cmd_accept");
        @(posedge clk);
        #1 cmd_valid = 0;
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while (active && n < limit) begin
            @(posedge clk);
            n++;
        end
        if (active) begin
            fail_now("layer_done");
            do_reset();
        end else begin
            repeat (2) @(posedge clk);
            chk("cfg_q_empty", cfg_q.size(), 0);
            chk("req_q_empty", req_q.size(), 0);
        end
    endtask

    task automatic wait_issued(input int unsigned target, input int limit);
        int n;
        n = 0;
        while (issued < target && n < limit) begin
            @(posedge clk);
            n++;
        end
        if (issued < target) fail_now("wait_issued");
    endtask

    initial begin
        int unsigned e0, d0;
        rst_n = 0; cmd_valid = 0; cmd_img_h = 0; cmd_img_w = 0; cmd_ch_grp = 0; cmd_base = 0;
        m_cfg_ready = 0; m_rd_ready = 0; act_valid = 0; act_ready = 0;
        model_reset();
        err_seen = 0; done_seen = 0;
        repeat (3) @(posedge clk);
        #1 check_reset_outputs("init");
        rst_n = 1;
        mon_en = 1;

        // 1: basic layer, all readies high
        d0 = done_seen;
        send_cmd(2, 4, 1, 32'h1000);
        wait_idle(500);
        chk("t1_done_count", done_seen - d0, 1);

        // 2: credit cap with no consumption, then one row frees one credit
        act_r_pct = 0;
        send_cmd(8, 2, 1, 32'h0);
        wait_issued(4, 100);
        repeat (10) @(posedge clk);
        chk("t2_reqs_capped", issued, 4);
        act_r_pct = 100;
        wait_idle(1000);

        // 3: zero height rejected
        e0 = err_seen;
        send_cmd(0, 5, 3, 32'h3000);
        repeat (3) @(posedge clk);
        chk("t3_err_pulse", err_seen - e0, 1);

        // 4: config stalled in CFG0
        cfg_rdy_pct = 0;
        send_cmd(3, 3, 2, 32'h2000);
        repeat (6) @(posedge clk);
        chk("t4_cfg_pending", cfg_q.size(), 2);
        cfg_rdy_pct = 100;
        wait_idle(1000);

        // 5: reset mid-run, then a minimal layer
        act_v_pct = 0;
        send_cmd(8, 2, 1, 32'h40);
        wait_issued(3, 100);
        do_reset();
        act_v_pct = 100;
        d0 = done_seen;
        send_cmd(1, 1, 1, 32'h500);
        wait_idle(200);
        chk("t5_done_count", done_seen - d0, 1);

        // 6: starvation counter over 10 RUN cycles
        act_v_pct = 0;
        act_r_pct = 100;
        send_cmd(2, 2, 1, 32'h0);
        begin
            int n;
            n = 0;
            while (!run_m && n < 100) begin
                @(posedge clk);
                n++;
            end
            if (!run_m) fail_now("t6_run");
        end
        repeat (10) @(posedge clk);
        #1;
`ifdef ACT_SCHED_PERF_EN
        chk("t6_perf_starve", perf_starve, 10);
`else
        chk("t6_perf_starve_off", perf_starve, 0);
`endif
        act_v_pct = 100;
        wait_idle(500);

        // Randomized layers
        for (int i = 0; i < 40; i++) begin
            int h, w, g;
            h = $urandom_range(4, 1);
            w = $urandom_range(4, 1);
            g = $urandom_range(3, 1);
            if ($urandom_range(7) == 0) h = 0;
            if ($urandom_range(11) == 0) g = 0;
            cfg_rdy_pct = $urandom_range(100, 30);
            rd_rdy_pct  = $urandom_range(100, 30);
            act_v_pct   = $urandom_range(100, 30);
            act_r_pct   = $urandom_range(100, 30);
            d0 = done_seen;
            e0 = err_seen;
            send_cmd(h, w, g, $urandom);
            if (h == 0 || g == 0) begin
                repeat (3) @(posedge clk);
                chk("rand_err", err_seen - e0, 1);
            end else begin
                wait_idle(3000);
                chk("rand_done", done_seen - d0, 1);
            end
        end

        mon_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
